// File: rtl/redcpu_pkg.sv
// Shared RedCPU definitions: ALU opcodes, flag bit positions, default widths
// and the execute-stage buffer occupancy encoding.
package redcpu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int RADDR_DEF = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/alu.sv
// Combinational RedCPU ALU; r carries one extra bit for carry/borrow and the
// last bit shifted out on SHL.
module alu
  import redcpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       act,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH:0]   r
);

  always_comb begin
    r = '0;
    case (act)
      ALU_ADD: r = {1'b0, op1} + {1'b0, op2};
      ALU_SUB: r = {1'b0, op1} - {1'b0, op2};
      ALU_AND: r = {1'b0, op1 & op2};
      ALU_OR:  r = {1'b0, op1 | op2};
      ALU_XOR: r = {1'b0, op1 ^ op2};
      // Full-width shift amount: anything past WIDTH naturally yields zero
      ALU_SHL: r = {1'b0, op1} << op2;
      ALU_SHR: r = {1'b0, op1 >> op2};
      ALU_NOT: r = {1'b0, ~op1};
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/exec_flags.sv
// Combinational Z/C/N/V derivation for one ALU operation.
module exec_flags
  import redcpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       act,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH:0]   r,
  output logic [3:0]       flags
);

  logic signed [WIDTH:0] sa, sb, ssum, sdif;

  always_comb begin
    sa   = {op1[WIDTH-1], op1};
    sb   = {op2[WIDTH-1], op2};
    ssum = sa + sb;
    sdif = sa - sb;

    flags        = '0;
    flags[FLG_Z] = (r[WIDTH-1:0] == '0);
    flags[FLG_N] = r[WIDTH-1];
    // Overflow shows as disagreement between the sign-extended top two bits
    case (act)
      ALU_ADD: begin
        flags[FLG_C] = r[WIDTH];
        flags[FLG_V] = ssum[WIDTH] ^ ssum[WIDTH-1];
      end
      ALU_SUB: begin
        flags[FLG_C] = r[WIDTH];
        flags[FLG_V] = sdif[WIDTH] ^ sdif[WIDTH-1];
      end
      ALU_SHL: flags[FLG_C] = r[WIDTH];
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// RedCPU execute stage: ALU plus a two-entry (output + skid) result buffer
// with registered in_ready, and the Z/C/N/V flags register.
module exec_stage
  import redcpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_act,
  input  logic [WIDTH-1:0] in_op1,
  input  logic [WIDTH-1:0] in_op2,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_setf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [RADDR-1:0] out_rd,
  output logic [3:0]       flags
);

  logic [WIDTH:0]   r_p0;
  logic [3:0]       flg_p0;
  occ_t             state, state_nxt;
  logic             acc, drn;
  logic             ld_out, ld_skid, mv_skid;
  logic             rdy_p1;
  logic [WIDTH-1:0] res_p1, skid_res_p1;
  logic [RADDR-1:0] rd_p1, skid_rd_p1;
  logic [3:0]       flg_p1;

  alu #(.WIDTH(WIDTH)) u_alu (
    .act (in_act),
    .op1 (in_op1),
    .op2 (in_op2),
    .r   (r_p0)
  );

  exec_flags #(.WIDTH(WIDTH)) u_flags (
    .act   (in_act),
    .op1   (in_op1),
    .op2   (in_op2),
    .r     (r_p0),
    .flags (flg_p0)
  );

  assign acc = in_valid && rdy_p1;
  assign drn = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    mv_skid   = 1'b0;
    case (state)
      OCC_EMPTY: if (acc) begin
        state_nxt = OCC_ONE;
        ld_out    = 1'b1;
      end
      OCC_ONE: begin
        if (acc && drn) begin
          ld_out = 1'b1;
        end else if (acc) begin
          state_nxt = OCC_TWO;
          ld_skid   = 1'b1;
        end else if (drn) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: if (drn) begin
        state_nxt = OCC_ONE;
        mv_skid   = 1'b1;
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // stage p0 (ALU + flag logic) -> p1 (output/skid buffer, flags register)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OCC_EMPTY;
      rdy_p1      <= 1'b0;
      flg_p1      <= '0;
      res_p1      <= '0;
      rd_p1       <= '0;
      skid_res_p1 <= '0;
      skid_rd_p1  <= '0;
    end else begin
      state  <= state_nxt;
      rdy_p1 <= (state_nxt != OCC_TWO);
      if (acc && in_setf) flg_p1 <= flg_p0;
      if (ld_out) begin
        res_p1 <= r_p0[WIDTH-1:0];
        rd_p1  <= in_rd;
      end else if (mv_skid) begin
        res_p1 <= skid_res_p1;
        rd_p1  <= skid_rd_p1;
      end
      if (ld_skid) begin
        skid_res_p1 <= r_p0[WIDTH-1:0];
        skid_rd_p1  <= in_rd;
      end
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = (state != OCC_EMPTY);
  assign out_res   = res_p1;
  assign out_rd    = rd_p1;
  assign flags     = flg_p1;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed cases plus randomized traffic
// against a queue-based reference model of results and flags.
module tb_exec_stage;
  import redcpu_pkg::*;

  localparam int W  = 16;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_act;
  logic [W-1:0]  in_op1, in_op2;
  logic [RA-1:0] in_rd;
  logic          in_setf;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [RA-1:0] out_rd;
  logic [3:0]    flags;

  always #5 clk = ~clk;

  exec_stage #(.WIDTH(W), .RADDR(RA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_op1    (in_op1),
    .in_op2    (in_op2),
    .in_rd     (in_rd),
    .in_setf   (in_setf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_rd    (out_rd),
    .flags     (flags)
  );

  typedef struct packed {
    logic [W-1:0]  res;
    logic [RA-1:0] rd;
  } exp_t;

  exp_t q[$];
  logic [3:0] fmodel;
  bit   rst_done;
  int   nerr = 0;
  int   nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU result, WIDTH+1 bits, from plain integer arithmetic
  function automatic logic [W:0] ref_alu(input logic [2:0] act, input int a, input int b);
    int r;
    case (act)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SHL: r = (b > W) ? 0 : (a << b);
      ALU_SHR: r = (b >= W) ? 0 : (a >> b);
      default: r = ~a & 32'hFFFF;
    endcase
    return r[W:0];
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] act, input int a, input int b);
    logic [W:0] r;
    int sa, sb, s;
    logic z, c, n, v;
    r  = ref_alu(act, a, b);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    z  = (r[W-1:0] == '0);
    n  = r[W-1];
    c  = (act == ALU_ADD || act == ALU_SUB || act == ALU_SHL) ? r[W] : 1'b0;
    v  = 1'b0;
    if (act == ALU_ADD) begin
      s = sa + sb;
      v = (s > 32767) || (s < -32768);
    end else if (act == ALU_SUB) begin
      s = sa - sb;
      v = (s > 32767) || (s < -32768);
    end
    return {z, c, n, v};
  endfunction

  // One clock: drive at negedge, check outputs, step the model on the posedge
  task automatic cycle(input logic v, input logic [2:0] act, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RA-1:0] rd,
                       input logic setf, input logic ordy, output logic acc);
    logic drn;
    logic [W:0] rr;
    exp_t e;
    in_valid  = v;
    in_act    = act;
    in_op1    = a;
    in_op2    = b;
    in_rd     = rd;
    in_setf   = setf;
    out_ready = ordy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(rst_done && q.size() < 2));
    if (out_valid && q.size() != 0) begin
      chk("out_res", 32'(out_res), 32'(q[0].res));
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
    end
    acc = v && rst_done && (q.size() < 2);
    drn = ordy && (q.size() != 0);
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      rr    = ref_alu(act, int'(a), int'(b));
      e.res = rr[W-1:0];
      e.rd  = rd;
      q.push_back(e);
      if (setf) fmodel = ref_flags(act, int'(a), int'(b));
    end
    rst_done = 1'b1;
    @(negedge clk);
    chk("flags", 32'(flags), 32'(fmodel));
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cycle(1'b0, 3'd0, '0, '0, '0, 1'b0, ordy, acc);
  endtask

  task automatic rand_cycle(input logic v, input logic ordy);
    logic acc;
    logic [W-1:0] b;
    b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 65535));
    cycle(v, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)), b,
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ordy, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_op1    = '0;
    in_op2    = '0;
    in_rd     = '0;
    in_setf   = 1'b0;
    out_ready = 1'b0;
    fmodel    = '0;
    rst_done  = 1'b0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_res", 32'(out_res), 32'(0));
    chk("rst_out_rd", 32'(out_rd), 32'(0));
    chk("rst_flags", 32'(flags), 32'(0));

    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Directed arithmetic and flag cases
    cycle(1'b1, ALU_ADD, 16'hFFFF, 16'h0001, 3'd2, 1'b1, 1'b1, acc);
    chk("add_res", 32'(out_res), 32'h0000);
    chk("add_rd", 32'(out_rd), 32'd2);
    chk("add_flags", 32'(flags), 32'b1100);
    cycle(1'b1, ALU_SUB, 16'h8000, 16'h0001, 3'd5, 1'b1, 1'b1, acc);
    chk("sub_res", 32'(out_res), 32'h7FFF);
    chk("sub_flags", 32'(flags), 32'b0001);
    cycle(1'b1, ALU_AND, 16'h0000, 16'h1234, 3'd1, 1'b0, 1'b1, acc);
    chk("and_res", 32'(out_res), 32'h0000);
    chk("and_noset_flags", 32'(flags), 32'b0001);
    cycle(1'b1, ALU_SHL, 16'h8001, 16'd1, 3'd3, 1'b1, 1'b1, acc);
    chk("shl_res", 32'(out_res), 32'h0002);
    chk("shl_flags", 32'(flags), 32'b0100);
    cycle(1'b1, ALU_SHR, 16'h8001, 16'd16, 3'd4, 1'b1, 1'b1, acc);
    chk("shr16_res", 32'(out_res), 32'h0000);
    chk("shr16_flags", 32'(flags), 32'b1000);
    cycle(1'b1, ALU_SHL, 16'h0001, 16'd16, 3'd6, 1'b1, 1'b1, acc);
    chk("shl16_flags", 32'(flags), 32'b1100);
    idle(1'b1);

    // Back-pressure: two ops absorbed, third held until a drain
    cycle(1'b1, ALU_OR,  16'h00F0, 16'h000F, 3'd1, 1'b0, 1'b0, acc);
    cycle(1'b1, ALU_XOR, 16'hAAAA, 16'hFFFF, 3'd2, 1'b0, 1'b0, acc);
    chk("bp_ready_low", 32'(in_ready), 32'(0));
    cycle(1'b1, ALU_NOT, 16'h1234, 16'h0000, 3'd3, 1'b0, 1'b0, acc);
    chk("bp_op3_held", 32'(acc), 32'(0));
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++)
      cycle(1'b1, ALU_NOT, 16'h1234, 16'h0000, 3'd3, 1'b0, 1'b1, acc);
    chk("bp_op3_accepted", 32'(acc), 32'(1));
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
    chk("bp_drained", 32'(out_valid), 32'(0));

    // Streaming at full rate
    for (int i = 0; i < 100; i++) rand_cycle(1'b1, 1'b1);
    idle(1'b1);

    // Random valid / back-pressure mix
    for (int i = 0; i < 300; i++)
      rand_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);

    // Asynchronous reset while holding two results
    cycle(1'b1, ALU_ADD, 16'hFFFF, 16'h0001, 3'd7, 1'b1, 1'b0, acc);
    cycle(1'b1, ALU_SUB, 16'h0003, 16'h0001, 3'd6, 1'b0, 1'b0, acc);
    chk("pre_rst_full", 32'(in_ready), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(0));
    chk("arst_flags", 32'(flags), 32'(0));
    q.delete();
    fmodel   = '0;
    rst_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 20; i++) rand_cycle(1'b1, 1'b1);
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
